eth_tx_fcs_ctrl: RTL and testbench

//  Transmit-side frame sequencer for the GMII/Ethernet TX path. Accepts a payload byte stream
//  and emits a contiguous GMII frame: preamble + SFD, payload, zero pad to minimum length,
//  4-byte FCS, then the inter-frame gap. Owns one crc32 instance: clears it per frame and

---
 rtl/eth_tx_pkg.sv | 43 ++++
 rtl/eth_tx_fcs_ctrl_crc32.sv | 43 ++++
 rtl/eth_tx_fcs_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_eth_tx_fcs_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit frame sequencer.
//   tx_state_e  : sequencer states, IDLE -> PRE -> DATA -> PAD -> FCS -> IFG
//   tx_beat_t   : one byte slot travelling down the transmit delay line
//   crc32_next  : one-byte update of the reflected CRC-32 register (poly 0x04C11DB7)
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAD  = 3'd3,
    FCS  = 3'd4,
    IFG  = 3'd5
  } tx_state_e;

  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [7:0]  PRE_BYTE      = 8'h55;
  localparam logic [7:0]  PAD_BYTE      = 8'h00;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  // en: slot drives txen; er: slot drives txer (aborted frame);
  // fcs: slot is replaced by crc byte fcs_idx when it reaches the txd register.
  typedef struct packed {
    logic       en;
    logic       er;
    logic       fcs;
    logic [1:0] fcs_idx;
    logic [7:0] data;
  } tx_beat_t;

  // Bit-serial, LSB-first update; Ethernet sends each byte LSB first.
  function automatic logic [31:0] crc32_next(input logic [31:0] lfsr, input logic [7:0] d);
    logic [31:0] nxt;
    logic        fb;
    nxt = lfsr;
    for (int i = 0; i < 8; i++) begin
      fb  = nxt[0] ^ d[i];
      nxt = {1'b0, nxt[31:1]} ^ (fb ? CRC_POLY_REFL : 32'h0);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/eth_tx_fcs_ctrl_crc32.sv
// crc32: Ethernet FCS generator with a 2-cycle update latency.
//   c   in   clock
//   r   in   synchronous clear to the all-ones seed (wins over dv)
//   dv  in   d is a frame byte to fold into the CRC
//   d   in   [7:0] frame byte
//   crc out  [31:0] finished FCS (complemented register), byte 0 = crc[7:0]
// A byte presented in cycle t is registered at t+1 and folded in, so it is
// reflected in crc from cycle t+2 on.
module crc32
  import eth_tx_pkg::*;
(
  input  logic        c,
  input  logic        r,
  input  logic        dv,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic        dv_q, dv_d;
  logic [7:0]  d_q, d_d;
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    dv_d   = dv & ~r;
    d_d    = d;
    lfsr_d = lfsr_q;
    if (r) begin
      lfsr_d = 32'hFFFF_FFFF;
    end else if (dv_q) begin
      lfsr_d = crc32_next(lfsr_q, d_q);
    end
  end

  // No reset: the sequencer clears the CRC with r at the start of every frame.
  always_ff @(posedge c) begin
    dv_q   <= dv_d;
    d_q    <= d_d;
    lfsr_q <= lfsr_d;
  end

  assign crc = ~lfsr_q;

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// eth_tx_fcs_ctrl: GMII transmit frame sequencer.
// Turns a payload byte stream into preamble + SFD, payload, zero pad, FCS and
// inter-frame gap on a registered GMII interface.
//   c            in   clock, one byte per cycle
//   rst_n        in   asynchronous reset, active low
//   in_data      in   [7:0] payload byte
//   in_valid     in   in_data valid
//   in_last      in   last payload byte of the frame
//   in_ready     out  byte accepted when in_valid & in_ready (high only in DATA)
//   txd/txen/txer out GMII transmit bus, registered
//   busy         out  sequencer not in IDLE
//   frame_done   out  pulse while the last FCS byte is on txd
//   underrun     out  pulse while the aborted-frame error byte is on txd
//   frame_count  out  [15:0] completed frames, wraps
//   dbg_state    out  [2:0] current sequencer state
// Handshake: a byte moves when in_valid and in_ready are both high at a rising
// edge of c; in_valid low while in_ready is high is a payload bubble and aborts
// the frame.
module eth_tx_fcs_ctrl
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int ENABLE_PAD   = 1,
  parameter int IFG_BYTES    = 12
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  txd,
  output logic        txen,
  output logic        txer,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic [15:0] frame_count,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);
  // The IDLE cycle that launches the next frame is part of the gap, so the
  // IFG state itself lasts one cycle less than the gap.
  localparam logic [15:0] IFG_LAST = 16'((IFG_BYTES > 1) ? IFG_BYTES - 2 : 0);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;          // preamble index / byte count / FCS index / gap count
  logic [15:0] cnt_inc;
  tx_beat_t    beat_s0;               // stage-0 slot produced this cycle
  tx_beat_t    d1_q;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txer_q, frame_done_q, underrun_q;
  logic        done_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        crc_clr, crc_dv;
  logic [7:0]  crc_din;
  logic [31:0] crc;

  crc32 u_crc32 (
    .c   (c),
    .r   (crc_clr),
    .dv  (crc_dv),
    .d   (crc_din),
    .crc (crc)
  );

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Sequencer: next state, counter and stage-0 slot.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_s0  = '0;
    crc_clr  = 1'b0;
    crc_dv   = 1'b0;
    crc_din  = in_data;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = PRE;
          cnt_d   = '0;
          crc_clr = 1'b1;
        end
      end
      PRE: begin
        beat_s0.en = 1'b1;
        if (cnt_q >= PRE_LAST) begin
          beat_s0.data = SFD;
          state_d      = DATA;
          cnt_d        = '0;
        end else begin
          beat_s0.data = PRE_BYTE;
          cnt_d        = cnt_q + 16'd1;
        end
      end
      DATA: begin
        in_ready   = 1'b1;
        beat_s0.en = 1'b1;
        if (!in_valid) begin
          // Bubble: emit one error slot and drop straight into the gap.
          beat_s0.er   = 1'b1;
          beat_s0.data = PAD_BYTE;
          state_d      = IFG;
          cnt_d        = '0;
        end else begin
          beat_s0.data = in_data;
          crc_dv       = 1'b1;
          cnt_d        = cnt_inc;
          if (in_last) begin
            if ((ENABLE_PAD != 0) && (cnt_inc < MIN_CNT)) begin
              state_d = PAD;
            end else begin
              state_d = FCS;
              cnt_d   = '0;
            end
          end
        end
      end
      PAD: begin
        beat_s0.en   = 1'b1;
        beat_s0.data = PAD_BYTE;
        crc_dv       = 1'b1;
        crc_din      = PAD_BYTE;
        cnt_d        = cnt_inc;
        if (cnt_inc >= MIN_CNT) begin
          state_d = FCS;
          cnt_d   = '0;
        end
      end
      FCS: begin
        // FCS slots carry only the byte index; the CRC byte is chosen one
        // stage later, when the last payload/pad byte has been folded in.
        beat_s0.en      = 1'b1;
        beat_s0.fcs     = 1'b1;
        beat_s0.fcs_idx = cnt_q[1:0];
        cnt_d           = cnt_q + 16'd1;
        if (cnt_q[1:0] == 2'd3) begin
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      IFG: begin
        if (cnt_q >= IFG_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output stage: txd register loads either the delayed byte or the FCS byte.
  always_comb begin
    txd_d = d1_q.data;
    if (d1_q.fcs) begin
      case (d1_q.fcs_idx)
        2'd0:    txd_d = crc[7:0];
        2'd1:    txd_d = crc[15:8];
        2'd2:    txd_d = crc[23:16];
        default: txd_d = crc[31:24];
      endcase
    end
    done_d        = d1_q.fcs && (d1_q.fcs_idx == 2'd3);
    frame_count_d = frame_count_q + {15'd0, done_d};
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      d1_q          <= '0;
      txd_q         <= '0;
      txen_q        <= 1'b0;
      txer_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      d1_q          <= beat_s0;
      txd_q         <= txd_d;
      txen_q        <= d1_q.en;
      txer_q        <= d1_q.er;
      frame_done_q  <= done_d;
      underrun_q    <= d1_q.er;
      frame_count_q <= frame_count_d;
    end
  end

  assign txd         = txd_q;
  assign txen        = txen_q;
  assign txer        = txer_q;
  assign frame_done  = frame_done_q;
  assign underrun    = underrun_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Bench for eth_tx_fcs_ctrl: a default-parameter instance and an ENABLE_PAD=0
// instance. Expected GMII bytes are queued when a frame is issued; monitors
// pop and compare every txen=1 cycle.
// Queue entry: [10] data don't-care, [9] frame_done, [8] txer/underrun, [7:0] txd.
module tb_eth_tx_fcs_ctrl;

  localparam int IFG = 12;

  logic c = 1'b0;
  always #5 c = ~c;

  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_last, np_en;
  logic        np_in_valid;

  logic        in_ready, txen, txer, busy, frame_done, underrun;
  logic [7:0]  txd;
  logic [15:0] frame_count;
  logic [2:0]  dbg_state;

  logic        np_in_ready, np_txen, np_txer, np_busy, np_frame_done, np_underrun;
  logic [7:0]  np_txd;
  logic [15:0] np_frame_count;
  logic [2:0]  np_dbg_state;

  assign np_in_valid = in_valid & np_en;

  eth_tx_fcs_ctrl u_dut (
    .c(c), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .txd(txd), .txen(txen), .txer(txer), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .frame_count(frame_count),
    .dbg_state(dbg_state)
  );

  eth_tx_fcs_ctrl #(.ENABLE_PAD(0)) u_np (
    .c(c), .rst_n(rst_n), .in_data(in_data), .in_valid(np_in_valid), .in_last(in_last),
    .in_ready(np_in_ready), .txd(np_txd), .txen(np_txen), .txer(np_txer), .busy(np_busy),
    .frame_done(np_frame_done), .underrun(np_underrun), .frame_count(np_frame_count),
    .dbg_state(np_dbg_state)
  );

  int          tests = 0;
  int          failed = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_np_q[$];
  logic [7:0]  pl [0:127];
  logic [15:0] exp_count;

  int run_len = 0, gap_len = 0, last_run = 0, last_gap = 0, un_seen = 0;
  bit seen_frame = 0;
  int np_run = 0, np_last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC-32 (zlib), table-free reflected form.
  function automatic logic [31:0] crc_upd(input logic [31:0] cr, input logic [7:0] b);
    logic [31:0] x;
    x = cr ^ {24'h0, b};
    for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  // Expected frame for the default instance; abort_at >= 0 models a bubble
  // after abort_at accepted bytes.
  task automatic push_frame(input int n, input int abort_at);
    logic [31:0] cr;
    int          total;
    cr = 32'hFFFF_FFFF;
    for (int k = 0; k < 7; k++) exp_q.push_back({3'b000, 8'h55});
    exp_q.push_back({3'b000, 8'hD5});
    if (abort_at >= 0) begin
      for (int k = 0; k < abort_at; k++) exp_q.push_back({3'b000, pl[k]});
      exp_q.push_back({3'b101, 8'h00});
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({3'b000, pl[k]});
        cr = crc_upd(cr, pl[k]);
      end
      for (total = n; total < 60; total++) begin
        exp_q.push_back({3'b000, 8'h00});
        cr = crc_upd(cr, 8'h00);
      end
      cr = ~cr;
      exp_q.push_back({3'b000, cr[7:0]});
      exp_q.push_back({3'b000, cr[15:8]});
      exp_q.push_back({3'b000, cr[23:16]});
      exp_q.push_back({3'b010, cr[31:24]});
      exp_count = exp_count + 16'd1;
    end
  endtask

  // Driver: present bytes at the falling edge; a byte counts as taken when
  // in_ready is high at that point (it is sampled at the next rising edge).
  task automatic send_frame(input int n, input int drop_at);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge c);
      guard++;
      if (i == drop_at && in_ready) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        i = n;
      end else begin
        in_valid = 1'b1;
        in_data  = pl[i];
        in_last  = (i == n - 1);
        if (in_ready) i++;
      end
    end
    check("send_done", (i >= n), 1);
    @(posedge c);
    #1;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || exp_np_q.size() != 0 || busy || np_busy) && g < 3000) begin
      @(negedge c);
      g++;
    end
    check("drain", (g < 3000), 1);
    @(negedge c);
  endtask

  // Monitor for the default instance.
  always @(negedge c) begin
    logic [10:0] e;
    if (!rst_n) begin
      run_len    = 0;
      gap_len    = 0;
      seen_frame = 0;
    end else if (txen) begin
      if (run_len == 0 && seen_frame) begin
        last_gap = gap_len;
        check("ifg_min", (gap_len >= IFG), 1);
      end
      run_len++;
      gap_len = 0;
      if (underrun) un_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_txen: got txd 0x%0h, expected no frame", txd);
      end else begin
        e = exp_q.pop_front();
        check("txd", {frame_done, underrun, txer, (e[10] ? 8'h00 : txd)},
              {e[9], e[8], e[8], (e[10] ? 8'h00 : e[7:0])});
      end
    end else begin
      if (run_len != 0) begin
        last_run   = run_len;
        run_len    = 0;
        seen_frame = 1;
      end
      if (seen_frame) gap_len++;
      check("idle_flags", {frame_done, underrun, txer}, 3'b000);
    end
  end

  // Monitor for the no-pad instance.
  always @(negedge c) begin
    logic [10:0] e;
    if (!rst_n) begin
      np_run = 0;
    end else if (np_txen) begin
      np_run++;
      if (exp_np_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL np_unexpected_txen: got txd 0x%0h, expected no frame", np_txd);
      end else begin
        e = exp_np_q.pop_front();
        check("np_txd", {np_frame_done, np_underrun, np_txer, np_txd}, {e[9], e[8], e[8], e[7:0]});
      end
    end else if (np_run != 0) begin
      np_last_run = np_run;
      np_run      = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fcs_hand [0:3];
    int g;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    np_en     = 1'b0;
    exp_count = 16'd0;
    repeat (3) @(negedge c);
    check("rst_tx",   {txen, txer, txd}, 10'h0);
    check("rst_ctl",  {busy, in_ready, frame_done, underrun, dbg_state}, 7'h0);
    check("rst_cnt",  frame_count, 16'h0);
    check("rst_np",   {np_txen, np_busy, np_in_ready, np_dbg_state, np_frame_count}, 22'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge c);

    // 1: "123456789" on both instances; no-pad FCS is the zlib check value.
    for (int k = 0; k < 9; k++) pl[k] = 8'h31 + 8'(k);
    fcs_hand[0] = 8'h26; fcs_hand[1] = 8'h39; fcs_hand[2] = 8'hF4; fcs_hand[3] = 8'hCB;
    np_en = 1'b1;
    push_frame(9, -1);
    for (int k = 0; k < 7; k++) exp_np_q.push_back({3'b000, 8'h55});
    exp_np_q.push_back({3'b000, 8'hD5});
    for (int k = 0; k < 9; k++) exp_np_q.push_back({3'b000, pl[k]});
    for (int k = 0; k < 3; k++) exp_np_q.push_back({3'b000, fcs_hand[k]});
    exp_np_q.push_back({3'b010, fcs_hand[3]});
    send_frame(9, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    np_en = 1'b0;
    check("np_run_len", np_last_run, 21);
    check("np_frame_count", np_frame_count, 16'd1);
    check("t1_run_len", last_run, 72);
    check("t1_frame_count", frame_count, exp_count);

    // 2: 14-byte payload padded to 60.
    for (int k = 0; k < 14; k++) pl[k] = 8'h10 + 8'(3 * k);
    push_frame(14, -1);
    send_frame(14, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    check("t2_run_len", last_run, 72);
    check("t2_frame_count", frame_count, exp_count);

    // 3: back-to-back 64-byte frames with in_valid held high.
    for (int k = 0; k < 64; k++) pl[k] = 8'(k) ^ 8'hA5;
    push_frame(64, -1);
    push_frame(64, -1);
    send_frame(64, -1);
    send_frame(64, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    check("t3_gap", last_gap, IFG);
    check("t3_run_len", last_run, 76);
    check("t3_frame_count", frame_count, exp_count);

    // 4: bubble at byte 20 aborts; the following frame is normal.
    for (int k = 0; k < 30; k++) pl[k] = 8'hC0 + 8'(k);
    push_frame(30, 20);
    send_frame(30, 20);
    wait_drain();
    check("t4_underruns", un_seen, 1);
    check("t4_count_kept", frame_count, exp_count);
    for (int k = 0; k < 10; k++) pl[k] = 8'h80 - 8'(k);
    push_frame(10, -1);
    send_frame(10, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    check("t4_next_count", frame_count, exp_count);

    // 5: reset while FCS byte 2 is on txd, then a clean frame.
    for (int k = 0; k < 20; k++) pl[k] = 8'h5A ^ 8'(7 * k);
    push_frame(20, -1);
    send_frame(20, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    g = 0;
    do begin
      @(posedge c);
      g++;
    end while (exp_q.size() != 2 && g < 500);
    check("t5_reach_fcs2", (g < 500), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_txen_drop", {txen, busy, frame_done}, 3'b000);
    check("t5_count_clr", frame_count, 16'h0);
    exp_q.delete();
    exp_count = 16'd0;
    repeat (2) @(negedge c);
    rst_n = 1'b1;
    repeat (2) @(negedge c);
    for (int k = 0; k < 25; k++) pl[k] = 8'h21 + 8'(k);
    push_frame(25, -1);
    send_frame(25, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    check("t5_frame_count", frame_count, exp_count);

    // 6: single-byte frame with the counter one below wrap.
    force u_dut.frame_count_q = 16'hFFFF;
    @(negedge c);
    release u_dut.frame_count_q;
    @(negedge c);
    exp_count = 16'hFFFF;
    check("t6_preload", frame_count, exp_count);
    pl[0] = 8'hA5;
    push_frame(1, -1);
    send_frame(1, -1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    check("t6_run_len", last_run, 72);
    check("t6_wrap", frame_count, exp_count);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
